// File: rtl/pwm_pkg.sv
// Shared types and constants for the multi-channel PWM.
package pwm_pkg;

  localparam int unsigned DEF_WIDTH   = 8;
  localparam int unsigned DEF_CH      = 4;
  localparam int unsigned DEF_PRESC_W = 8;

  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } dir_e;

  function automatic int unsigned cnt_max(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/pwm_multi_if.sv
// Control/status bundle between register logic and pwm_multi.
// Carries the mode bit only when PWM_CENTER_ALIGNED_EN is defined.
interface pwm_multi_if
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned CH      = DEF_CH,
  parameter int unsigned PRESC_W = DEF_PRESC_W
);
  logic                  en;
  logic [PRESC_W-1:0]    presc;
  logic [CH*WIDTH-1:0]   duty;
  logic                  duty_upd;
  logic [CH-1:0]         pol;
`ifdef PWM_CENTER_ALIGNED_EN
  logic                  mode;
`endif
  logic [CH-1:0]         pulse;
  logic                  upd_pending;
  logic                  period_start;

  modport master (
    output en, presc, duty, duty_upd, pol,
`ifdef PWM_CENTER_ALIGNED_EN
    output mode,
`endif
    input  pulse, upd_pending, period_start
  );

  modport slave (
    input  en, presc, duty, duty_upd, pol,
`ifdef PWM_CENTER_ALIGNED_EN
    input  mode,
`endif
    output pulse, upd_pending, period_start
  );
endinterface

// File: rtl/pwm_timebase.sv
// Shared prescaler + period counter; flags the period boundary tick.
// PWM_CENTER_ALIGNED_EN adds the up/down counting mode.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned PRESC_W = DEF_PRESC_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [PRESC_W-1:0] presc,
`ifdef PWM_CENTER_ALIGNED_EN
  input  logic               mode,
`endif
  output logic [WIDTH-1:0]   cnt,
  output logic               boundary,
  output logic               period_start
);
  localparam logic [WIDTH-1:0]   MAX   = WIDTH'(cnt_max(WIDTH));
  localparam logic [WIDTH-1:0]   ONE   = WIDTH'(1);
  localparam logic [PRESC_W-1:0] P_ONE = PRESC_W'(1);

  logic [PRESC_W-1:0] pcnt_q, pcnt_nxt;
  logic [WIDTH-1:0]   cnt_q, cnt_nxt;
  dir_e               dir_q, dir_nxt;
  logic               center_q, center_nxt;
  logic               ps_q;
  logic               tick;
  logic               bnd;
  logic               mode_sel;

`ifdef PWM_CENTER_ALIGNED_EN
  assign mode_sel = mode;
`else
  assign mode_sel = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q   <= '0;
      cnt_q    <= '0;
      dir_q    <= UP;
      center_q <= 1'b0;
      ps_q     <= 1'b0;
    end else begin
      pcnt_q   <= pcnt_nxt;
      cnt_q    <= cnt_nxt;
      dir_q    <= dir_nxt;
      center_q <= center_nxt;
      ps_q     <= bnd;
    end
  end

  // >= so a presc lowered below the running count still ticks at the next compare
  always_comb begin
    tick       = en && (pcnt_q >= presc);
    pcnt_nxt   = pcnt_q;
    cnt_nxt    = cnt_q;
    dir_nxt    = dir_q;
    center_nxt = center_q;
    bnd        = 1'b0;
    if (en) pcnt_nxt = tick ? '0 : pcnt_q + P_ONE;
    if (tick) begin
      if (center_q) begin
        if (dir_q == UP) begin
          if (cnt_q == MAX) begin
            dir_nxt = DOWN;
            cnt_nxt = MAX - ONE;
          end else begin
            cnt_nxt = cnt_q + ONE;
          end
        end else begin
          cnt_nxt = cnt_q - ONE;
          if (cnt_q == ONE) begin
            bnd     = 1'b1;
            dir_nxt = UP;
          end
        end
      end else begin
        cnt_nxt = cnt_q + ONE;
        dir_nxt = UP;
        bnd     = (cnt_q == MAX);
      end
      if (bnd) center_nxt = mode_sel;
    end
  end

  assign cnt          = cnt_q;
  assign boundary     = bnd;
  assign period_start = ps_q;
endmodule

// File: rtl/pwm_multi.sv
// CH-channel PWM with shared timebase and double-buffered duty values.
// Optional PWM_CENTER_ALIGNED_EN exposes the center-aligned mode bit.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned CH      = DEF_CH,
  parameter int unsigned PRESC_W = DEF_PRESC_W
) (
  input logic        clk,
  input logic        rst_n,
  pwm_multi_if.slave bus
);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(cnt_max(WIDTH));

  logic [WIDTH-1:0] cnt;
  logic             boundary;
  logic             pending_q;
  logic [CH-1:0]    level;

  pwm_timebase #(
    .WIDTH   (WIDTH),
    .PRESC_W (PRESC_W)
  ) u_timebase (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (bus.en),
    .presc        (bus.presc),
`ifdef PWM_CENTER_ALIGNED_EN
    .mode         (bus.mode),
`endif
    .cnt          (cnt),
    .boundary     (boundary),
    .period_start (bus.period_start)
  );

  // A strobe on the boundary re-arms pending, so the fresh value waits a period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            pending_q <= 1'b0;
    else if (bus.duty_upd) pending_q <= 1'b1;
    else if (boundary)     pending_q <= 1'b0;
  end

  for (genvar k = 0; k < CH; k++) begin : g_ch
    logic [WIDTH-1:0] staging;
    logic [WIDTH-1:0] active;
    logic             level_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        staging <= '0;
        active  <= '0;
        level_q <= 1'b0;
      end else begin
        if (bus.duty_upd)          staging <= bus.duty[k*WIDTH +: WIDTH];
        if (boundary && pending_q) active  <= staging;
        if (active == '0)          level_q <= 1'b0;
        else if (active == MAX)    level_q <= 1'b1;
        else                       level_q <= (cnt < active);
      end
    end

    assign level[k] = level_q;
  end

  assign bus.pulse       = level ^ bus.pol;
  assign bus.upd_pending = pending_q;
endmodule

// File: tb/tb_pwm_multi.sv
// Directed self-checking bench for pwm_multi (WIDTH=8, CH=4).
module tb_pwm_multi;
  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  int   hi [4];
  int   ps_cnt;
  logic last_ps;

  always #5 clk = ~clk;

  pwm_multi_if #(.WIDTH(8), .CH(4), .PRESC_W(8)) bus ();

  pwm_multi #(.WIDTH(8), .CH(4), .PRESC_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    for (int k = 0; k < 4; k++) hi[k] = 0;
    ps_cnt  = 0;
    last_ps = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      for (int k = 0; k < 4; k++) hi[k] += int'(bus.pulse[k]);
      ps_cnt  += int'(bus.period_start);
      last_ps  = bus.period_start;
    end
  endtask

  task automatic wait_ps(input string tag, input int budget);
    int n = 0;
    do begin
      step();
      n++;
    end while (bus.period_start !== 1'b1 && n < budget);
    chk(tag, 32'(bus.period_start), 32'd1);
  endtask

  task automatic strobe(input logic [31:0] d);
    bus.duty     = d;
    bus.duty_upd = 1'b1;
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.en       = 1'b0;
    bus.presc    = 8'd0;
    bus.duty     = '0;
    bus.duty_upd = 1'b0;
    bus.pol      = 4'b0010;
`ifdef PWM_CENTER_ALIGNED_EN
    bus.mode     = 1'b0;
`endif

    // reset state
    step(); step();
    chk("rst_pulse", 32'(bus.pulse), 32'b0010);
    chk("rst_pend", 32'(bus.upd_pending), 32'd0);
    chk("rst_ps", 32'(bus.period_start), 32'd0);

    // idle after release: logical outputs stay low
    rst_n  = 1'b1;
    bus.en = 1'b1;
    clr(); run(256);
    chk("idle_ch0", hi[0], 0);
    chk("idle_ch1", hi[1], 256);
    chk("idle_ch3", hi[3], 0);
    chk("idle_pend", 32'(bus.upd_pending), 32'd0);

    // duty sweep with ch0 polarity inverted
    bus.pol = 4'b0001;
    strobe({8'hFF, 8'h80, 8'h01, 8'h00});
    step();
    bus.duty_upd = 1'b0;
    chk("sweep_pend_set", 32'(bus.upd_pending), 32'd1);
    wait_ps("sweep_wait", 300);
    chk("sweep_pend_clr", 32'(bus.upd_pending), 32'd0);
    clr(); run(256);
    chk("sweep_ch0", hi[0], 256);
    chk("sweep_ch1", hi[1], 1);
    chk("sweep_ch2", hi[2], 128);
    chk("sweep_ch3", hi[3], 256);
    chk("sweep_ps", ps_cnt, 1);
    chk("sweep_ps_last", 32'(last_ps), 32'd1);

    // shadowing: 0x20 active, 0xC0 staged at cnt=0x10
    bus.pol = 4'b0000;
    strobe({8'h00, 8'h00, 8'h00, 8'h20});
    step();
    bus.duty_upd = 1'b0;
    wait_ps("shadow_wait", 300);
    clr(); run(16);
    strobe({8'h00, 8'h00, 8'h00, 8'hC0});
    run(1);
    bus.duty_upd = 1'b0;
    chk("shadow_pend_a", 32'(bus.upd_pending), 32'd1);
    run(238);
    chk("shadow_pend_b", 32'(bus.upd_pending), 32'd1);
    run(1);
    chk("shadow_ps", 32'(last_ps), 32'd1);
    chk("shadow_pend_clr", 32'(bus.upd_pending), 32'd0);
    chk("shadow_hi_old", hi[0], 32);
    clr(); run(256);
    chk("shadow_hi_new", hi[0], 192);

    // collision: strobe on the boundary tick
    strobe({8'h00, 8'h00, 8'h00, 8'h10});
    clr(); run(1);
    bus.duty_upd = 1'b0;
    run(254);
    strobe({8'h00, 8'h00, 8'h00, 8'h30});
    run(1);
    bus.duty_upd = 1'b0;
    chk("coll_ps", 32'(last_ps), 32'd1);
    chk("coll_pend", 32'(bus.upd_pending), 32'd1);
    chk("coll_hi_c0", hi[0], 192);
    clr(); run(256);
    chk("coll_hi_10", hi[0], 16);
    chk("coll_pend_clr", 32'(bus.upd_pending), 32'd0);
    clr(); run(256);
    chk("coll_hi_30", hi[0], 48);

    // prescaler: presc=3 gives a 1024-clk period
    bus.presc = 8'd3;
    strobe({8'h00, 8'h00, 8'h00, 8'h40});
    step();
    bus.duty_upd = 1'b0;
    wait_ps("presc_wait", 2000);
    clr(); run(1024);
    chk("presc_hi", hi[0], 256);
    chk("presc_ps", ps_cnt, 1);
    chk("presc_ps_last", 32'(last_ps), 32'd1);

    // freeze for 50 clk while high
    clr(); run(100);
    bus.en = 1'b0;
    run(50);
    chk("freeze_hi", hi[0], 150);
    chk("freeze_ps", ps_cnt, 0);
    bus.en = 1'b1;
    run(924);
    chk("freeze_total", hi[0], 306);
    chk("freeze_ps_last", 32'(last_ps), 32'd1);
    chk("freeze_ps_cnt", ps_cnt, 1);

    // reset mid-period discards staged value
    strobe({8'hFF, 8'hFF, 8'hFF, 8'hFF});
    step();
    bus.duty_upd = 1'b0;
    chk("rst2_pend_pre", 32'(bus.upd_pending), 32'd1);
    bus.pol = 4'b0100;
    rst_n   = 1'b0;
    #1;
    chk("rst2_pulse", 32'(bus.pulse), 32'b0100);
    chk("rst2_pend", 32'(bus.upd_pending), 32'd0);
    step(); step();
    rst_n   = 1'b1;
    bus.pol = 4'b0000;
    clr(); run(1200);
    chk("rst2_ch0", hi[0], 0);
    chk("rst2_ch3", hi[3], 0);
    chk("rst2_pend_post", 32'(bus.upd_pending), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
